// File: rtl/mem_pkg.sv
// Shared definitions for the data memory slice.
// Holds the access-size encodings, the controller state type, the response
// pipeline entry layout and the big-endian byte-lane enable helper.
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic {INIT, RUN} mem_state_t;

   // One slot of the response pipeline. Stores and errors travel with a zero
   // word and SIZE_WORD so the output extraction yields zero for them.
   typedef struct packed {
      logic        valid;
      logic        error;
      logic [1:0]  lane;
      logic [1:0]  size;
      logic        unsigned_load;
      logic [31:0] word;
   } resp_entry_t;

   // Bit i of the result enables word bits [8*i+7:8*i]. Offset 0 is the most
   // significant lane, so masks are shifted right by the byte offset.
   function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                              input logic [1:0] lane);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SIZE_BYTE: mask = 4'b1000 >> lane;
         SIZE_HALF: mask = 4'b1100 >> lane;
         SIZE_WORD: mask = 4'b1111;
         default:   mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response pipeline for the data memory.
// Ports:
//   clock, reset_n  : clock and synchronous active-low reset (flushes entries)
//   entry           : response slot captured on every clock edge
//   resp_valid      : oldest entry has matured
//   data_out        : extracted and extended load data, zero otherwise
//   error           : matured entry was a rejected request
module mem_resp_pipe
   import mem_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  resp_entry_t entry,
   output logic        resp_valid,
   output logic [31:0] data_out,
   output logic        error
);

   resp_entry_t stages [READ_LATENCY];
   resp_entry_t tail;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Shift register; reset drops any in-flight responses.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= entry;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign tail = stages[READ_LATENCY-1];

   // Pick the addressed lane(s) big-endian and right-justify them.
   always_comb begin
      sel_byte = 8'h00;
      case (tail.lane)
         2'd0: sel_byte = tail.word[31:24];
         2'd1: sel_byte = tail.word[23:16];
         2'd2: sel_byte = tail.word[15:8];
         default: sel_byte = tail.word[7:0];
      endcase
      sel_half = tail.lane[1] ? tail.word[15:0] : tail.word[31:16];
   end

   always_comb begin
      data_out = 32'h0;
      if (tail.valid) begin
         case (tail.size)
            SIZE_BYTE: data_out = {{24{sel_byte[7] & ~tail.unsigned_load}}, sel_byte};
            SIZE_HALF: data_out = {{16{sel_half[15] & ~tail.unsigned_load}}, sel_half};
            SIZE_WORD: data_out = tail.word;
            default:   data_out = 32'h0;
         endcase
      end
   end

   assign resp_valid = tail.valid;
   assign error      = tail.valid & tail.error;

endmodule

// File: rtl/data_memory_pipe.sv
// Big-endian byte-addressable data memory with valid/ready requests and a
// fixed read latency. Clears itself after reset before accepting requests.
// Ports:
//   clock, reset_n        : clock and synchronous active-low reset
//   req_valid, req_ready  : request handshake (ready only once cleared)
//   read_write            : 1 store, 0 load
//   address, data_in      : byte address and right-justified store data
//   size, unsigned_load   : access width and load extension mode
//   resp_valid, data_out  : in-order response and load result
//   error                 : response was misaligned, out of range or bad size
module data_memory_pipe
   import mem_pkg::*;
#(
   parameter int          DEPTH_BYTES  = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h80020000,
   parameter int          READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        read_write,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   input  logic [1:0]  size,
   input  logic        unsigned_load,
   output logic        resp_valid,
   output logic [31:0] data_out,
   output logic        error
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int IDX_W = $clog2(WORDS);

   logic [31:0]      mem [WORDS];
   mem_state_t       state;
   logic [IDX_W-1:0] clear_ptr;

   logic [31:0]      off;
   logic [IDX_W-1:0] word_idx;
   logic             out_of_range;
   logic             misaligned;
   logic             bad;
   logic             accept;
   logic             do_load;
   logic [3:0]       lanes;
   logic [31:0]      wdata;
   resp_entry_t      entry;

   // Subtraction wraps, so addresses below the base land far out of range.
   assign off          = address - BASE_ADDR;
   assign word_idx     = off[IDX_W+1:2];
   assign out_of_range = off >= 32'(DEPTH_BYTES);
   assign misaligned   = ((size == SIZE_HALF) && off[0]) ||
                         ((size == SIZE_WORD) && (off[1:0] != 2'b00));
   assign bad          = out_of_range | misaligned | (size == SIZE_ILLEGAL);

   assign req_ready = (state == RUN);
   assign accept    = req_valid & req_ready;
   assign do_load   = accept & ~read_write & ~bad;
   assign lanes     = lane_enable(size, off[1:0]);

   // Replicate narrow store data across the word; lane enables pick the target.
   always_comb begin
      wdata = data_in;
      case (size)
         SIZE_BYTE: wdata = {4{data_in[7:0]}};
         SIZE_HALF: wdata = {2{data_in[15:0]}};
         default:   wdata = data_in;
      endcase
   end

   // Clear sequencer: walks every word once after reset, then runs forever.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= INIT;
         clear_ptr <= '0;
      end else if (state == INIT) begin
         clear_ptr <= clear_ptr + 1'b1;
         if (clear_ptr == IDX_W'(WORDS - 1)) begin
            state <= RUN;
         end
      end
   end

   // Storage array: zero fill during INIT, lane-masked stores in RUN.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (state == INIT) begin
            mem[clear_ptr] <= '0;
         end else if (accept && read_write && !bad) begin
            for (int i = 0; i < 4; i++) begin
               if (lanes[i]) begin
                  mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end
      end
   end

   // Raw word is sampled at acceptance, which gives read-after-store ordering
   // because the store committed on the preceding edge.
   always_comb begin
      entry               = '0;
      entry.valid         = accept;
      entry.error         = accept & bad;
      entry.lane          = off[1:0];
      entry.size          = do_load ? size : SIZE_WORD;
      entry.unsigned_load = unsigned_load;
      entry.word          = do_load ? mem[word_idx] : 32'h0;
   end

   mem_resp_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_resp_pipe (
      .clock      (clock),
      .reset_n    (reset_n),
      .entry      (entry),
      .resp_valid (resp_valid),
      .data_out   (data_out),
      .error      (error)
   );

endmodule

// File: tb/tb_data_memory_pipe.sv
// Randomised self-checking bench for data_memory_pipe with a byte-array
// reference model and a due-cycle response scoreboard.
module tb_data_memory_pipe;
   import mem_pkg::*;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h80020000;
   localparam int          LAT   = 3;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        read_write;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [1:0]  size;
   logic        unsigned_load;
   logic        resp_valid;
   logic [31:0] data_out;
   logic        error;

   data_memory_pipe #(
      .DEPTH_BYTES  (DEPTH),
      .BASE_ADDR    (BASE),
      .READ_LATENCY (LAT)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .read_write    (read_write),
      .address       (address),
      .data_in       (data_in),
      .size          (size),
      .unsigned_load (unsigned_load),
      .resp_valid    (resp_valid),
      .data_out      (data_out),
      .error         (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_mem [DEPTH];
   int         assert_count = 0;
   int         fail_count   = 0;
   int         cyc          = 0;
   logic       last_ready;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
   endtask

   // Behavioural access: byte array, big-endian, with the error rules.
   task automatic modelAccess(input logic rw, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz,
                              input logic u, output logic err,
                              output logic [31:0] res);
      logic [31:0] off;
      int          n;
      logic [31:0] val;
      off = a - BASE;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err = (off >= DEPTH) || (sz == 2'd3) || (off % n != 0);
      res = 32'h0;
      if (err) return;
      if (rw) begin
         for (int i = 0; i < n; i++)
            model_mem[off + i] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
      end else begin
         val = 32'h0;
         for (int i = 0; i < n; i++) val = (val << 8) | 32'(model_mem[off + i]);
         if (!u && n == 1 && val[7])  val = val | 32'hFFFFFF00;
         if (!u && n == 2 && val[15]) val = val | 32'hFFFF0000;
         res = val;
      end
   endtask

   // Advance to the next sampling point and check the response outputs.
   task automatic sampleCycle();
      @(negedge clock);
      cyc++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         checkOutput("resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("resp_data",  data_out, exp_q[0].data);
         checkOutput("resp_error", 32'(error), 32'(exp_q[0].err));
         void'(exp_q.pop_front());
      end else begin
         checkOutput("idle_valid", 32'(resp_valid), 32'd0);
         checkOutput("idle_data",  data_out, 32'h0);
         checkOutput("idle_error", 32'(error), 32'd0);
      end
      last_ready = req_ready;
   endtask

   task automatic applyStimulus(input logic v, input logic rw,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, input logic u);
      logic        err;
      logic [31:0] res;
      exp_t        e;
      sampleCycle();
      reset_n       = 1'b1;
      req_valid     = v;
      read_write    = rw;
      address       = a;
      data_in       = d;
      size          = sz;
      unsigned_load = u;
      if (v && last_ready) begin
         modelAccess(rw, a, d, sz, u, err, res);
         e.due  = cyc + LAT;
         e.err  = err;
         e.data = res;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0);
   endtask

   task automatic applyReset(input int n);
      for (int i = 0; i < n; i++) begin
         sampleCycle();
         if (i > 0) checkOutput("reset_ready", 32'(req_ready), 32'd0);
         reset_n   = 1'b0;
         req_valid = 1'b0;
         exp_q.delete();
      end
      modelClear();
   endtask

   // Hold a word load until accepted; counts the cycles spent clearing.
   task automatic waitInit(input logic [31:0] probe);
      int zeros;
      zeros = 0;
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'b1, 1'b0, probe, 32'h0, SIZE_WORD, 1'b0);
         if (last_ready) break;
         zeros++;
      end
      checkOutput("init_cycles", 32'(zeros), 32'd256);
      idle(LAT + 1);
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = 1'b0;
      read_write    = 1'b0;
      address       = 32'h0;
      data_in       = 32'h0;
      size          = SIZE_WORD;
      unsigned_load = 1'b0;
      modelClear();

      applyReset(3);
      waitInit(32'h80020010);

      // Word store then narrow and full loads of the same word.
      applyStimulus(1, 1, 32'h80020020, 32'h11223344, SIZE_WORD, 0);
      applyStimulus(1, 0, 32'h80020021, 32'h0, SIZE_BYTE, 0);
      applyStimulus(1, 0, 32'h80020022, 32'h0, SIZE_HALF, 0);
      applyStimulus(1, 0, 32'h80020020, 32'h0, SIZE_WORD, 0);
      idle(2);

      // Byte store with a negative value, signed and unsigned reads.
      applyStimulus(1, 1, 32'h80020023, 32'h000000F0, SIZE_BYTE, 0);
      applyStimulus(1, 0, 32'h80020023, 32'h0, SIZE_BYTE, 0);
      applyStimulus(1, 0, 32'h80020023, 32'h0, SIZE_BYTE, 1);
      applyStimulus(1, 0, 32'h80020020, 32'h0, SIZE_WORD, 0);
      idle(1);

      // Error cases, then confirm the word is untouched.
      applyStimulus(1, 0, 32'h80020022, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 1, 32'h80020021, 32'hDEADBEEF, SIZE_HALF, 0);
      applyStimulus(1, 0, 32'h80020400, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 0, 32'h8001FFFC, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 1, 32'h80020020, 32'hCAFEF00D, SIZE_ILLEGAL, 0);
      applyStimulus(1, 0, 32'h80020020, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 1, 32'h800203FE, 32'h0000A5C3, SIZE_HALF, 0);
      applyStimulus(1, 0, 32'h800203FC, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 0, 32'h800203FE, 32'h0, SIZE_HALF, 0);
      applyStimulus(1, 0, 32'h800203FE, 32'h0, SIZE_HALF, 1);
      idle(LAT + 1);

      // Back-to-back random traffic concentrated on a small window.
      for (int i = 0; i < 500; i++) begin
         logic        v, rw, u;
         logic [31:0] a;
         logic [1:0]  sz;
         v  = ($urandom_range(0, 3) != 0);
         rw = $urandom_range(0, 1) == 1;
         u  = $urandom_range(0, 1) == 1;
         sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       a = BASE + 32'($urandom_range(1020, 1100));
            1:       a = BASE - 32'($urandom_range(1, 8));
            default: a = BASE + 32'($urandom_range(0, 31));
         endcase
         applyStimulus(v, rw, a, $urandom, sz, u);
      end
      idle(LAT + 1);

      // Reset with loads in flight: they must vanish and memory must clear.
      applyStimulus(1, 1, 32'h80020040, 32'h5A5A5A5A, SIZE_WORD, 0);
      applyStimulus(1, 0, 32'h80020040, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 0, 32'h80020020, 32'h0, SIZE_WORD, 0);
      applyReset(2);
      waitInit(32'h80020040);
      applyStimulus(1, 0, 32'h80020020, 32'h0, SIZE_WORD, 0);
      applyStimulus(1, 0, 32'h800203FC, 32'h0, SIZE_WORD, 0);
      idle(LAT + 2);

      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
